// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, TX/RX state enums and the baud increment helper.
// Shared by uart_baud_gen and uart_core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_t;

  // round(baud * overSample * 2^accW / clkFreq), 64-bit intermediate
  function automatic longint unsigned baudInc(
    input longint unsigned clkFreq,
    input longint unsigned baud,
    input longint unsigned overSample,
    input int unsigned     accW
  );
    longint unsigned num;
    num = (baud * overSample) << accW;
    return (num + clkFreq / 2) / clkFreq;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional phase accumulator, one oversample tick per carry.
// Free-running; shared by the TX and RX halves of uart_core.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 512000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam longint unsigned INC64 =
    baudInc(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE), ACC_W);
  localparam logic [ACC_W:0] INC = (ACC_W + 1)'(INC64);

  logic [ACC_W:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[ACC_W-1:0]} + INC;
    end
  end

  assign tick = acc[ACC_W];

endmodule

// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with valid/ready TX and flagged RX.
// Define UART_BREAK_DET_EN to add the rx_break port and break handling.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 512000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int IDLE_BITS  = 2,
  parameter int ACC_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_idle,
  output logic                 rx_eop
`ifdef UART_BREAK_DET_EN
  ,
  output logic                 rx_break
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == PAR_ODD);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);
  localparam int IDLE_TH = IDLE_BITS * OVERSAMPLE;
  localparam int IW = $clog2(IDLE_TH + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TH);

  logic tick;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE),
    .ACC_W     (ACC_W)
  ) uBaud (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  txState_t             txState;
  logic [CW-1:0]        txCnt;
  logic [3:0]           txBit;
  logic [DATA_BITS-1:0] txShift;
  logic                 txPar;

  assign tx_ready = (txState == TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      txState <= TX_IDLE;
      txd     <= 1'b1;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      txPar   <= 1'b0;
    end else if (txState == TX_IDLE) begin
      if (tx_valid) begin
        txState <= TX_START;
        txd     <= 1'b0;
        txCnt   <= '0;
        txBit   <= '0;
        txShift <= tx_data;
        txPar   <= (^tx_data) ^ ODD;
      end
    end else if (tick) begin
      txCnt <= txCnt + 1'b1;
      if (txCnt == LAST) begin
        unique case (txState)
          TX_START: begin
            txState <= TX_DATA;
            txd     <= txShift[0];
            txShift <= txShift >> 1;
          end
          TX_DATA: begin
            txBit   <= txBit + 1'b1;
            txd     <= txShift[0];
            txShift <= txShift >> 1;
            if (txBit == DLAST) begin
              txBit <= '0;
              if (HAS_PAR) begin
                txState <= TX_PARITY;
                txd     <= txPar;
              end else begin
                txState <= TX_STOP;
                txd     <= 1'b1;
              end
            end
          end
          TX_PARITY: begin
            txState <= TX_STOP;
            txd     <= 1'b1;
          end
          TX_STOP: begin
            txBit <= txBit + 1'b1;
            if (txBit == SLAST) txState <= TX_IDLE;
          end
          default: txState <= TX_IDLE;
        endcase
      end
    end
  end

  logic rxS1, rxS2, rxPrev, rxFall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxS1   <= 1'b1;
      rxS2   <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxS1   <= rxd;
      rxS2   <= rxS1;
      rxPrev <= rxS2;
    end
  end

  assign rxFall = rxPrev & ~rxS2;

  rxState_t             rxState;
  logic [CW-1:0]        rxCnt;
  logic [3:0]           rxBit;
  logic [DATA_BITS-1:0] rxShift;
  logic                 rxParBit;
  logic                 parErr;

  assign parErr = HAS_PAR & (rxParBit ^ (^rxShift) ^ ODD);

`ifdef UART_BREAK_DET_EN
  logic isBreak, stopSample;
  assign isBreak = ~rxS2 & (rxShift == '0) & ~(HAS_PAR & rxParBit);
  assign stopSample = (rxState == RX_STOP) & tick & (rxCnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rxState       <= RX_IDLE;
      rxCnt         <= '0;
      rxBit         <= '0;
      rxShift       <= '0;
      rxParBit      <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_BREAK_DET_EN
      rx_break      <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef UART_BREAK_DET_EN
      rx_break <= 1'b0;
`endif
      unique case (rxState)
        RX_IDLE: begin
          if (rxFall) begin
            rxState <= RX_START;
            rxCnt   <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == HALF) begin
              rxCnt   <= '0;
              rxBit   <= '0;
              rxState <= rxS2 ? RX_IDLE : RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == LAST) begin
              rxShift <= {rxS2, rxShift[DATA_BITS-1:1]};
              rxBit   <= rxBit + 1'b1;
              if (rxBit == DLAST)
                rxState <= HAS_PAR ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == LAST) begin
              rxParBit <= rxS2;
              rxState  <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == LAST) begin
              rxState <= RX_IDLE;
`ifdef UART_BREAK_DET_EN
              if (isBreak) rx_break <= 1'b1;
              else
`endif
              begin
                rx_valid      <= 1'b1;
                rx_data       <= rxShift;
                rx_parity_err <= parErr;
                rx_frame_err  <= ~rxS2;
              end
            end
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  logic [IW-1:0] idleCnt;
  logic          idleNow;

`ifdef UART_BREAK_DET_EN
  logic          brkHold;
  logic [CW-1:0] hiCnt;

  // after a break, hold rx_idle off until the line is high a full bit
  always_ff @(posedge clk) begin
    if (rst) begin
      brkHold <= 1'b0;
      hiCnt   <= '0;
    end else if (stopSample & isBreak) begin
      brkHold <= 1'b1;
      hiCnt   <= '0;
    end else if (brkHold) begin
      if (!rxS2) begin
        hiCnt <= '0;
      end else if (tick) begin
        hiCnt <= hiCnt + 1'b1;
        if (hiCnt == LAST) brkHold <= 1'b0;
      end
    end
  end

  assign idleNow = (idleCnt >= IDLE_MAX) & ~brkHold;
`else
  assign idleNow = (idleCnt >= IDLE_MAX);
`endif

  // START only freezes the count so a rejected false start keeps rx_idle
  always_ff @(posedge clk) begin
    if (rst) begin
      idleCnt <= '0;
      rx_idle <= 1'b0;
      rx_eop  <= 1'b0;
    end else begin
      if (rxState != RX_IDLE && rxState != RX_START)
        idleCnt <= '0;
      else if (rxState == RX_IDLE && tick && idleCnt != IDLE_MAX)
        idleCnt <= idleCnt + 1'b1;
      rx_idle <= idleNow;
      rx_eop  <= idleNow & ~rx_idle;
    end
  end

endmodule
